// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN post-processing blocks: the reassembler
// state encoding and the kernel border width derived from the window size.
package cnn_pkg;

  // Reassembler control states: waiting for a frame to begin, or streaming it out.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Border width lost on each side by a square kernel of the given size.
  // A 3x3 kernel trims one pixel, a 5x5 kernel trims two, and so on.
  function automatic int border_width(input int buffer_size);
    return (buffer_size - 1) / 2;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column position counter walking a frame in raster order.
// Outputs the current position plus flags for the first pixel, the last
// pixel of a row and the last pixel of the frame, so the parent can
// decorate an output pixel in the same cycle it loads it.
module raster_counter #(
  parameter int ROW_SIZE = 540,
  parameter int NUM_ROWS = 540,
  parameter int COL_W    = $clog2(ROW_SIZE),
  parameter int ROW_W    = $clog2(NUM_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             start_of_frame,
  output logic             end_of_row,
  output logic             end_of_frame
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  assign start_of_frame = (row == '0) && (col == '0);
  assign end_of_row     = (col == COL_LAST);
  assign end_of_frame   = end_of_row && (row == ROW_LAST);

  // Step one position per advance; the column wraps into the next row and
  // the last row wraps back to the top of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (end_of_row) begin
        col <= '0;
        if (end_of_frame) begin
          row <= '0;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_reassembler.sv
// Frame reassembler: takes the interior pixels produced by a BUFFER_SIZE x
// BUFFER_SIZE kernel and rebuilds the full ROW_SIZE x NUM_ROWS frame,
// filling the border ring with PAD_VALUE. Output is a single register
// stage with valid/ready handshaking and start/end-of-row/end-of-frame marks.
module frame_reassembler
  import cnn_pkg::*;
#(
  parameter int                   WORD_SIZE   = 8,
  parameter int                   BUFFER_SIZE = 3,
  parameter int                   ROW_SIZE    = 540,
  parameter int                   NUM_ROWS    = 540,
  parameter logic [WORD_SIZE-1:0] PAD_VALUE   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] in_pixel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 frame_done
);

  localparam int B     = border_width(BUFFER_SIZE);
  localparam int COL_W = $clog2(ROW_SIZE);
  localparam int ROW_W = $clog2(NUM_ROWS);

  // Interior window bounds: first index inside, and first index past it.
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(B);
  localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(ROW_SIZE - B);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(B);
  localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(NUM_ROWS - B);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             start_of_frame;
  logic             end_of_row;
  logic             end_of_frame;
  logic             interior;
  logic             slot_open;
  logic             load;

  // Position counter names the next pixel to be loaded into the output register.
  raster_counter #(
    .ROW_SIZE(ROW_SIZE),
    .NUM_ROWS(NUM_ROWS),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W)
  ) u_raster_counter (
    .clk           (clk),
    .rst           (rst),
    .advance       (load),
    .col           (col),
    .row           (row),
    .start_of_frame(start_of_frame),
    .end_of_row    (end_of_row),
    .end_of_frame  (end_of_frame)
  );

  // A position is interior when it lies inside the border ring on both axes.
  assign interior = (row >= ROW_FIRST) && (row < ROW_LIMIT) &&
                    (col >= COL_FIRST) && (col < COL_LIMIT);

  // The output register can take a new pixel when it is empty or being drained.
  assign slot_open = (state == STREAM) && (!out_valid || out_ready);

  // Only interior positions consume input; in_valid is deliberately not used here.
  assign in_ready = slot_open && interior;

  // Border positions load unconditionally, interior ones only with a real input transfer.
  assign load = slot_open && (!interior || in_valid);

  // Completion pulse coincides with the downstream accepting the last pixel.
  assign frame_done = out_valid && out_ready && out_eof;

  // Control FSM and output register: loads a padded or forwarded pixel with its
  // position marks, holds it while the downstream stalls, and returns to IDLE
  // once the final pixel of the frame has been loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (in_valid) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            out_valid <= 1'b1;
            out_pixel <= interior ? in_pixel : PAD_VALUE;
            out_sof   <= start_of_frame;
            out_eol   <= end_of_row;
            out_eof   <= end_of_frame;
            if (end_of_frame) begin
              state <= IDLE;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reassembler.sv
// Testbench for frame_reassembler on a 5x4 frame with a 3x3 kernel border.
// A position-indexed reference model predicts every accepted output pixel
// from the queue of accepted inputs and the border rule.
module tb_frame_reassembler;

  localparam int WORD_SIZE    = 8;
  localparam int BUFFER_SIZE  = 3;
  localparam int ROW_SIZE     = 5;
  localparam int NUM_ROWS     = 4;
  localparam int B            = (BUFFER_SIZE - 1) / 2;
  localparam int FRAME_PIXELS = ROW_SIZE * NUM_ROWS;
  localparam logic [WORD_SIZE-1:0] PAD = 8'h00;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] out_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic                 out_eol;
  logic                 out_eof;
  logic                 frame_done;

  always #5 clk = ~clk;

  frame_reassembler #(
    .WORD_SIZE  (WORD_SIZE),
    .BUFFER_SIZE(BUFFER_SIZE),
    .ROW_SIZE   (ROW_SIZE),
    .NUM_ROWS   (NUM_ROWS),
    .PAD_VALUE  (PAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .frame_done(frame_done)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  // Reference model state
  logic [WORD_SIZE-1:0] accepted_q[$];
  int                   pos = 0;
  int                   frames_seen = 0;
  int                   done_pulses = 0;
  bit                   full_rate = 0;
  bit                   held_valid = 0;
  logic [WORD_SIZE-1:0] held_pixel;
  logic [2:0]           held_flags;
  bit                   last_in_xfer = 0;
  logic [WORD_SIZE-1:0] last_in_pixel;

  // Border rule: anything within B of any frame edge is padding.
  function automatic bit is_border(input int p);
    int r, c;
    r = p / ROW_SIZE;
    c = p % ROW_SIZE;
    return (r < B) || (r >= NUM_ROWS - B) || (c < B) || (c >= ROW_SIZE - B);
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Evaluate the handshake about to happen at the next rising edge and
  // compare the DUT against the model.
  task automatic checkOutput();
    logic                 out_xfer;
    logic                 in_xfer;
    logic [WORD_SIZE-1:0] exp_px;
    out_xfer = out_valid && out_ready;
    in_xfer  = in_valid && in_ready;

    if (last_in_xfer) begin
      checkValue("latency_valid", out_valid, 1);
      checkValue("latency_pixel", out_pixel, last_in_pixel);
    end
    if (held_valid) begin
      checkValue("stall_valid", out_valid, 1);
      checkValue("stall_pixel", out_pixel, held_pixel);
      checkValue("stall_flags", {out_sof, out_eol, out_eof}, held_flags);
    end
    if (full_rate && pos != 0) checkValue("no_bubble", out_valid, 1);
    checkValue("frame_done", frame_done, out_xfer && (pos == FRAME_PIXELS - 1));
    if (frame_done === 1'b1) done_pulses++;

    if (out_xfer) begin
      if (is_border(pos)) begin
        exp_px = PAD;
      end else begin
        checkValue("interior_has_input", accepted_q.size() != 0, 1);
        if (accepted_q.size() != 0) exp_px = accepted_q.pop_front();
        else exp_px = 'x;
      end
      checkValue("out_pixel", out_pixel, exp_px);
      checkValue("out_sof", out_sof, pos == 0);
      checkValue("out_eol", out_eol, (pos % ROW_SIZE) == ROW_SIZE - 1);
      checkValue("out_eof", out_eof, pos == FRAME_PIXELS - 1);
      pos = (pos + 1) % FRAME_PIXELS;
      if (pos == 0) frames_seen++;
    end
    if (in_xfer) accepted_q.push_back(in_pixel);

    last_in_xfer  = in_xfer;
    last_in_pixel = in_pixel;
    held_valid    = out_valid && !out_ready;
    held_pixel    = out_pixel;
    held_flags    = {out_sof, out_eol, out_eof};
  endtask

  // One clock of stimulus, driven on the falling edge and checked just after.
  task automatic applyStimulus(input logic iv, input logic [WORD_SIZE-1:0] px, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_pixel  = px;
    out_ready = ordy;
    #1;
    checkOutput();
  endtask

  // Hold reset for the given cycles, discard the model state and check reset values.
  task automatic doReset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    accepted_q.delete();
    pos          = 0;
    held_valid   = 0;
    last_in_xfer = 0;
    #1;
    checkValue("rst_out_valid", out_valid, 0);
    checkValue("rst_in_ready", in_ready, 0);
    checkValue("rst_frame_done", frame_done, 0);
    checkValue("rst_out_pixel", out_pixel, 0);
    checkValue("rst_flags", {out_sof, out_eol, out_eof}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int next_val;
    int frames_before;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;

    doReset(2);

    // With no input the block stays idle and never offers readiness.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'b1);
      checkValue("idle_in_ready", in_ready, 0);
      checkValue("idle_out_valid", out_valid, 0);
    end

    // Two back-to-back frames at full rate with inputs 1..12.
    full_rate = 1;
    next_val  = 1;
    for (int i = 0; i < 200 && frames_seen < 2; i++) begin
      applyStimulus(1'b1, 8'(next_val), 1'b1);
      if (in_valid && in_ready) next_val++;
    end
    full_rate = 0;
    checkValue("two_frames_done", frames_seen, 2);
    checkValue("two_frames_inputs", next_val, 13);

    // Downstream alternating ready, upstream always valid.
    frames_before = frames_seen;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'b1, 8'($urandom), (i % 2) == 0);
    end
    checkValue("toggle_progress", frames_seen > frames_before, 1);

    // Upstream gaps on interior positions.
    frames_before = frames_seen;
    for (int i = 0; i < 150; i++) begin
      applyStimulus((i % 7) > 2, 8'($urandom), 1'b1);
    end
    checkValue("gap_progress", frames_seen > frames_before, 1);

    // Fully random handshakes on both sides.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    // Reset in the middle of a frame, then restart with a fresh full frame.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
    end
    doReset(1);
    frames_before = frames_seen;
    full_rate = 1;
    next_val  = 7;
    for (int i = 0; i < 100 && frames_seen == frames_before; i++) begin
      applyStimulus(1'b1, 8'(next_val), 1'b1);
      if (in_valid && in_ready) next_val++;
    end
    full_rate = 0;
    checkValue("restart_frame_done", frames_seen, frames_before + 1);

    // Drain and confirm the completion pulse count matches the frames seen.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'b1);
    end
    checkValue("done_pulse_count", done_pulses, frames_seen);

    // Reset once more and confirm the block stays quiet without input.
    doReset(1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'b1);
      checkValue("final_idle_in_ready", in_ready, 0);
      checkValue("final_idle_out_valid", out_valid, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/frame_reassembler.md
FRAME_REASSEMBLER -- requirements
Module: frame_reassembler

Interface
REQ-001 Parameter WORD_SIZE, default 8, pixel width in bits.
REQ-002 Parameter BUFFER_SIZE, default 3, square window size of the upstream kernel; odd, at least 3; border width B = (BUFFER_SIZE-1)/2.
REQ-003 Parameter ROW_SIZE, default 540, output pixels per row.
REQ-004 Parameter NUM_ROWS, default 540, output rows per frame.
REQ-005 Parameter PAD_VALUE, default 0, WORD_SIZE-wide value emitted for border pixels.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_pixel  input  WORD_SIZE  interior result pixel, raster order.
REQ-009 in_valid  input  1  in_pixel is valid.
REQ-010 in_ready  output  1  block accepts in_pixel this cycle.
REQ-011 out_pixel  output  WORD_SIZE  full-frame raster pixel.
REQ-012 out_valid  output  1  out_* carry a valid pixel.
REQ-013 out_ready  input  1  downstream accepts the pixel this cycle.
REQ-014 out_sof / out_eol / out_eof  output  1 each  marks pixel (row 0, col 0) / col ROW_SIZE-1 / (row NUM_ROWS-1, col ROW_SIZE-1).
REQ-015 frame_done  output  1  one-cycle pulse on the cycle the out_eof pixel is accepted.

Function
REQ-016 Block rebuilds a ROW_SIZE x NUM_ROWS frame from (ROW_SIZE-2B) x (NUM_ROWS-2B) interior pixels; positions with row<B, row>=NUM_ROWS-B, col<B or col>=ROW_SIZE-B are border and carry PAD_VALUE.
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-018 Counters row/col name the next position loaded into the output register; they advance by one per load, col wraps ROW_SIZE-1 -> 0 with row+1, and row wraps NUM_ROWS-1 -> 0.
REQ-019 Output register loads when (!out_valid || out_ready) and either the position is border (no input consumed) or the position is interior and an input transfer occurs.
REQ-020 in_ready = (state==STREAM) && position interior && (!out_valid || out_ready); in_ready never depends combinationally on in_valid.
REQ-021 Latency: an accepted interior pixel appears on out_pixel exactly one cycle after acceptance; a border pixel appears one cycle after its load slot opens.
REQ-022 While out_valid && !out_ready, out_pixel, out_sof, out_eol and out_eof hold stable.
REQ-023 With out_ready held high and in_valid always high, throughput is one output pixel per cycle with no bubbles.
REQ-024 States: IDLE, STREAM. IDLE -> STREAM when in_valid=1; no load occurs in the IDLE cycle. STREAM -> IDLE on the load of the out_eof pixel.
REQ-025 In IDLE, in_ready=0, no new load occurs, and a pending out_valid pixel is still held until accepted.
REQ-026 A load and a transfer of the previous pixel in the same cycle is legal; out_valid stays 1.
REQ-027 An input stall at an interior position halts loading; border positions never wait on in_valid.
REQ-028 frame_done asserts only on the out_eof output transfer; counters are already 0 at that point.
REQ-029 Counter widths are $clog2(ROW_SIZE) and $clog2(NUM_ROWS).

Reset
REQ-030 On rst: state=IDLE, row=col=0, out_valid=0, out_pixel=0, out_sof=out_eol=out_eof=0, frame_done=0, in_ready=0.
REQ-031 rst asserted mid-frame discards the partial frame and the held output pixel; the next frame starts at (0,0) with out_sof.

Structure
REQ-032 Shared package cnn_pkg holds the state enum (IDLE, STREAM) and the border-width function of BUFFER_SIZE.
REQ-033 One sub-module, raster_counter (row/col counters with wrap and end-of-row/end-of-frame flags), is instantiated once.

Verification (ROW_SIZE=5, NUM_ROWS=4, BUFFER_SIZE=3, PAD_VALUE=0)
REQ-034 Inputs 1..6 streamed, out_ready=1 -> 20 outputs: row0 all 0; row1 0,1,2,3,0; row2 0,4,5,6,0; row3 all 0; sof on 1st, eol on 5th/10th/15th/20th, eof and frame_done on 20th.
REQ-035 out_ready toggled 1,0 each cycle -> identical sequence; out_* stable during every stall cycle.
REQ-036 in_valid low for 3 cycles before input 4 -> output stalls at (2,1) only; no PAD_VALUE inserted in interior.
REQ-037 Two frames back-to-back (inputs 1..12) -> two 20-pixel frames, frame_done pulses twice, second sof directly follows first eof.
REQ-038 rst for one cycle after input 3 accepted -> all outputs 0 next cycle; restart with inputs 7..12 yields a full frame with interior 7..12.
REQ-039 Reset value check: after rst with in_valid=0 -> out_valid=0, in_ready=0, frame_done=0 indefinitely.
